// File: rtl/fsk2_frame_rx.sv
// Frame receiver behind the fsk2 demodulator: start bit, DATA_W bits MSB first, stop bit,
// each bit decided by a 3-sample majority vote around mid-bit.
module fsk2_frame_rx #(
    parameter int unsigned BIT_CYCLES  = 50,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam int unsigned IW = $clog2(DATA_W + 1);
    localparam int unsigned H  = BIT_CYCLES / 2;

    localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q, armed_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    logic rx_s;
    logic sync_full;
    logic bit_v;
    logic decide;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    // The synchroniser resets to 1; arming waits until every stage holds a real line sample,
    // so a line held low out of reset cannot masquerade as idle-high followed by a start edge.
    assign sync_full = fill_q[SYNC_STAGES-1];
    assign bit_v     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign decide    = (cnt_q == CNT_DEC);

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            sync_q  <= '1;
            fill_q  <= '0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            smp_q   <= '1;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_in};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= rx_s;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q | (sync_full & rx_s);
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (cnt_q == CNT_S0) smp_d[0] = rx_s;
        if (cnt_q == CNT_S1) smp_d[1] = rx_s;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && prev_q && !rx_s) begin
                    state_d = START;
                    idx_d   = '0;
                end
            end
            START: begin
                if (decide) state_d = bit_v ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_d = {shift_q[DATA_W-2:0], bit_v};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                // Returning to IDLE at the decision absorbs the rest of the stop bit,
                // so a start bit immediately after it is still seen as a falling edge.
                if (decide) begin
                    if (bit_v) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsk2_frame_rx.sv
// Directed bench for fsk2_frame_rx: ideal frames, back-to-back, false start, stop error,
// sample-point glitch and mid-frame reset.
module tb_fsk2_frame_rx;

    localparam int BC  = 50;
    localparam int H   = BC / 2;
    localparam int LAT = 879;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        rx_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          vcnt = 0;
    int          ecnt = 0;
    int          both_cnt = 0;
    int          last_vcyc = 0;
    int          prev_vcyc = 0;
    int          last_ecyc = 0;
    logic [15:0] last_data = '0;
    logic [15:0] prev_data = '0;
    logic        busy_seen = 1'b0;
    int          start_cyc = 0;

    fsk2_frame_rx #(.BIT_CYCLES(50), .DATA_W(16), .SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (data_valid) begin
            prev_vcyc = last_vcyc;
            prev_data = last_data;
            last_vcyc = cyc;
            last_data = data_out;
            vcnt++;
        end
        if (frame_err) begin
            last_ecyc = cyc;
            ecnt++;
        end
        if (data_valid && frame_err) both_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Drives nbits frame bits (start, 16 data MSB first, stop); bit gf is inverted at phase gc.
    task automatic drive_bits(input logic [15:0] word, input logic stop_b,
                              input int gf, input int gc, input int nbits);
        logic [17:0] fr;
        logic        b;
        fr = {1'b0, word, stop_b};
        start_cyc = cyc + 1;
        for (int f = 0; f < nbits; f++) begin
            for (int c = 0; c < BC; c++) begin
                b = fr[17-f];
                if (f == gf && c == gc) b = ~b;
                rx_in = b;
                @(posedge sys_clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        rx_in     = 1'b1;
        idle(5);
        chk_cnt++; if (data_out !== 16'h0000) $display("FAIL reset_data got=%h want=0000", data_out); else pass_cnt++;
        chk_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", data_valid); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_err got=%b want=0", frame_err); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
        sys_rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_single;
        int v0, e0;
        v0 = vcnt; e0 = ecnt;
        drive_bits(16'hFEC8, 1'b1, -1, -1, 18);
        idle(5);
        chk_cnt++; if (vcnt - v0 !== 1) $display("FAIL single_count got=%0d want=1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (last_vcyc - start_cyc !== LAT) $display("FAIL single_latency got=%0d want=%0d", last_vcyc - start_cyc, LAT); else pass_cnt++;
        chk_cnt++; if (data_out !== 16'hFEC8) $display("FAIL single_data got=%h want=fec8", data_out); else pass_cnt++;
        chk_cnt++; if (ecnt - e0 !== 0) $display("FAIL single_err got=%0d want=0", ecnt - e0); else pass_cnt++;
        idle(20);
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vcnt;
        drive_bits(16'hFEC8, 1'b1, -1, -1, 18);
        drive_bits(16'h7EF0, 1'b1, -1, -1, 18);
        idle(20);
        chk_cnt++; if (vcnt - v0 !== 2) $display("FAIL b2b_count got=%0d want=2", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (last_vcyc - prev_vcyc !== 900) $display("FAIL b2b_spacing got=%0d want=900", last_vcyc - prev_vcyc); else pass_cnt++;
        chk_cnt++; if (prev_data !== 16'hFEC8) $display("FAIL b2b_first got=%h want=fec8", prev_data); else pass_cnt++;
        chk_cnt++; if (last_data !== 16'h7EF0) $display("FAIL b2b_second got=%h want=7ef0", last_data); else pass_cnt++;
    endtask

    task automatic test_false_start;
        int v0, e0;
        v0 = vcnt; e0 = ecnt;
        busy_seen = 1'b0;
        rx_in = 1'b0;
        idle(10);
        rx_in = 1'b1;
        idle(100);
        chk_cnt++; if (busy_seen !== 1'b1) $display("FAIL false_busy_seen got=%b want=1", busy_seen); else pass_cnt++;
        chk_cnt++; if (vcnt - v0 !== 0) $display("FAIL false_valid got=%0d want=0", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (ecnt - e0 !== 0) $display("FAIL false_err got=%0d want=0", ecnt - e0); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL false_idle got=%b want=0", busy); else pass_cnt++;
    endtask

    task automatic test_frame_err;
        int v0, e0;
        v0 = vcnt; e0 = ecnt;
        drive_bits(16'h1234, 1'b0, -1, -1, 18);
        rx_in = 1'b1;
        idle(20);
        chk_cnt++; if (ecnt - e0 !== 1) $display("FAIL ferr_count got=%0d want=1", ecnt - e0); else pass_cnt++;
        chk_cnt++; if (last_ecyc - start_cyc !== LAT) $display("FAIL ferr_latency got=%0d want=%0d", last_ecyc - start_cyc, LAT); else pass_cnt++;
        chk_cnt++; if (vcnt - v0 !== 0) $display("FAIL ferr_valid got=%0d want=0", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (data_out !== 16'h7EF0) $display("FAIL ferr_hold got=%h want=7ef0", data_out); else pass_cnt++;
        drive_bits(16'hA5A5, 1'b1, -1, -1, 18);
        idle(20);
        chk_cnt++; if (vcnt - v0 !== 1) $display("FAIL ferr_next_count got=%0d want=1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (data_out !== 16'hA5A5) $display("FAIL ferr_next_data got=%h want=a5a5", data_out); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = vcnt; e0 = ecnt;
        // Driver phase H+1 of a bit reaches the receiver's cnt=H sample point.
        drive_bits(16'h00FF, 1'b1, 8, H + 1, 18);
        idle(20);
        chk_cnt++; if (vcnt - v0 !== 1) $display("FAIL glitch_count got=%0d want=1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (data_out !== 16'h00FF) $display("FAIL glitch_data got=%h want=00ff", data_out); else pass_cnt++;
        chk_cnt++; if (ecnt - e0 !== 0) $display("FAIL glitch_err got=%0d want=0", ecnt - e0); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int v0, e0;
        drive_bits(16'hC3C3, 1'b1, -1, -1, 10);
        rx_in = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk_cnt++; if (data_out !== 16'h0000) $display("FAIL mid_rst_data got=%h want=0000", data_out); else pass_cnt++;
        chk_cnt++; if (data_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b want=0", data_valid); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL mid_rst_err got=%b want=0", frame_err); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b want=0", busy); else pass_cnt++;
        idle(3);
        v0 = vcnt; e0 = ecnt;
        busy_seen = 1'b0;
        sys_rst_n = 1'b1;
        idle(200);
        chk_cnt++; if (busy_seen !== 1'b0) $display("FAIL mid_low_no_start got=%b want=0", busy_seen); else pass_cnt++;
        chk_cnt++; if ((vcnt - v0) + (ecnt - e0) !== 0) $display("FAIL mid_low_pulses got=%0d want=0", (vcnt - v0) + (ecnt - e0)); else pass_cnt++;
        rx_in = 1'b1;
        idle(20);
        drive_bits(16'hBEEF, 1'b1, -1, -1, 18);
        idle(20);
        chk_cnt++; if (vcnt - v0 !== 1) $display("FAIL mid_next_count got=%0d want=1", vcnt - v0); else pass_cnt++;
        chk_cnt++; if (data_out !== 16'hBEEF) $display("FAIL mid_next_data got=%h want=beef", data_out); else pass_cnt++;
        chk_cnt++; if (last_vcyc - start_cyc !== LAT) $display("FAIL mid_next_latency got=%0d want=%0d", last_vcyc - start_cyc, LAT); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        chk_cnt++; if (both_cnt !== 0) $display("FAIL valid_err_overlap got=%0d want=0", both_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
